// File: rtl/prog1_pkg.sv
// Shared types and helpers for the program-1 Hamming(16,11) SECDED sequencer and its
// future checker siblings.
package prog1_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRdLo,
        StRdHi,
        StWrHi,
        StWrLo,
        StDone
    } state_e;

    localparam int unsigned P8_POS = 8;
    localparam int unsigned P4_POS = 4;
    localparam int unsigned P2_POS = 2;
    localparam int unsigned P1_POS = 1;
    localparam int unsigned P0_POS = 0;

    // Codeword layout: {d11..d5, p8, d4, d3, d2, p4, d1, p2, p1, p0}.
    function automatic logic [15:0] ham_pack(input logic [11:1] d);
        logic [15:0] cw;
        cw          = '0;
        cw[15:9]    = d[11:5];
        cw[7:5]     = d[4:2];
        cw[3]       = d[1];
        cw[P8_POS]  = ^d[11:5];
        cw[P4_POS]  = (^d[11:8]) ^ (^d[4:2]);
        cw[P2_POS]  = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        cw[P1_POS]  = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        cw[P0_POS]  = (^d) ^ cw[P8_POS] ^ cw[P4_POS] ^ cw[P2_POS] ^ cw[P1_POS];
        return cw;
    endfunction

endpackage

// File: rtl/hamming_enc.sv
// Combinational Hamming(16,11) SECDED encoder: 11 data bits in, packed codeword out.
module hamming_enc
    import prog1_pkg::*;
(
    input  logic [10:0] data,
    output logic [15:0] code
);

    assign code = ham_pack(data);

endmodule

// File: rtl/prog1_hamming_seq.sv
// Program-1 sequencer: reads 11-bit messages from data memory, encodes them and writes
// 16-bit codewords back, sharing the memory port through an external req/gnt arbiter.
module prog1_hamming_seq
    import prog1_pkg::*;
#(
    parameter int unsigned NUM_MSG  = 15,
    parameter int unsigned SRC_BASE = 0,
    parameter int unsigned DST_BASE = 30,
    parameter int unsigned AW       = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mem_gnt,
    input  logic [7:0]    mem_rdat,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wdat,
    output logic          busy,
    output logic          done
);

    localparam logic [6:0] LastIdx = 7'(NUM_MSG - 1);

    state_e      state_q, state_d;
    logic [6:0]  i_q, i_d;
    logic [11:1] d_q, d_d;
    logic        done_q, done_d;
    logic [15:0] code;

    logic [AW-1:0] lo_off, src_lo, dst_lo;

    hamming_enc u_enc (
        .data (d_q),
        .code (code)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            i_q     <= '0;
            d_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            d_q     <= d_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        d_d     = d_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRdLo;
                    i_d     = '0;
                end
            end
            StRdLo: begin
                if (mem_gnt) begin
                    d_d[8:1] = mem_rdat;
                    state_d  = StRdHi;
                end
            end
            StRdHi: begin
                if (mem_gnt) begin
                    d_d[11:9] = mem_rdat[2:0];
                    state_d   = StWrHi;
                end
            end
            StWrHi: begin
                if (mem_gnt) state_d = StWrLo;
            end
            StWrLo: begin
                if (mem_gnt) begin
                    if (i_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        i_d     = i_q + 7'd1;
                        state_d = StRdLo;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // done rises one cycle after reaching DONE and drops on the edge that accepts a new start.
    assign done_d = (state_q == StDone) && !start;
    assign done   = done_q;

    assign lo_off = AW'({i_q, 1'b0});
    assign src_lo = AW'(SRC_BASE) + lo_off;
    assign dst_lo = AW'(DST_BASE) + lo_off;

    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wr_en = 1'b0;
        mem_wdat  = '0;
        unique case (state_q)
            StRdLo: begin
                mem_req  = 1'b1;
                mem_addr = src_lo;
            end
            StRdHi: begin
                mem_req  = 1'b1;
                mem_addr = src_lo + AW'(1);
            end
            StWrHi: begin
                mem_req   = 1'b1;
                mem_wr_en = 1'b1;
                mem_addr  = dst_lo + AW'(1);
                mem_wdat  = code[15:8];
            end
            StWrLo: begin
                mem_req   = 1'b1;
                mem_wr_en = 1'b1;
                mem_addr  = dst_lo;
                mem_wdat  = code[7:0];
            end
            default: ;
        endcase
    end

    assign busy = mem_req;

endmodule

// File: tb/tb_prog1_hamming_seq.sv
// Self-checking bench for prog1_hamming_seq: byte memory model, arbiter grant driven from
// the stimulus, and a position-based Hamming reference model.
module tb_prog1_hamming_seq;

    localparam int unsigned N   = 15;
    localparam int unsigned SRC = 0;
    localparam int unsigned DST = 30;

    logic       clk = 1'b0;
    logic       reset, start, mem_gnt;
    logic [7:0] mem_rdat;
    logic       mem_req, mem_wr_en, busy, done;
    logic [7:0] mem_addr, mem_wdat;

    logic [7:0] mem [256];
    int checks = 0;
    int errors = 0;
    int wr_count = 0;

    prog1_hamming_seq #(
        .NUM_MSG  (N),
        .SRC_BASE (SRC),
        .DST_BASE (DST),
        .AW       (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_gnt   (mem_gnt),
        .mem_rdat  (mem_rdat),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wr_en (mem_wr_en),
        .mem_wdat  (mem_wdat),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    assign mem_rdat = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_req && mem_wr_en && mem_gnt && !reset) begin
            mem[mem_addr] <= mem_wdat;
            wr_count      <= wr_count + 1;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Classic Hamming placement: data at non-power-of-two positions 1..15, parity p_k covers
    // every position with bit k set, bit 0 is overall parity.
    function automatic logic [15:0] ref_code(input logic [7:0] lo, input logic [7:0] hi);
        logic [10:0] d;
        logic [15:0] cw;
        int          di;
        logic        par;
        d  = {hi[2:0], lo};
        cw = '0;
        di = 0;
        for (int p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = d[di];
                di++;
            end
        end
        for (int k = 1; k < 16; k = k * 2) begin
            par = 1'b0;
            for (int p = 1; p < 16; p++) if ((p & k) != 0) par ^= cw[p];
            cw[k] = par;
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    task automatic load_random_src;
        for (int a = 0; a < 2 * N; a++) mem[SRC + a] <= 8'($urandom);
    endtask

    task automatic check_codes(input int n);
        logic [15:0] cw;
        for (int m = 0; m < n; m++) begin
            cw = ref_code(mem[SRC + 2 * m], mem[SRC + 2 * m + 1]);
            check("code_lo", 32'(mem[DST + 2 * m]), 32'(cw[7:0]));
            check("code_hi", 32'(mem[DST + 2 * m + 1]), 32'(cw[15:8]));
        end
    endtask

    task automatic check_idle_outputs;
        check("idle_req", 32'(mem_req), 32'd0);
        check("idle_addr", 32'(mem_addr), 32'd0);
        check("idle_wr_en", 32'(mem_wr_en), 32'd0);
        check("idle_wdat", 32'(mem_wdat), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
    endtask

    // Start a run with gnt high; verify the per-cycle address schedule and start-to-done latency.
    task automatic run(input int exp_lat, input int busy_start_at);
        int         cnt, m, ph;
        logic [7:0] ea;
        start = 1'b1;
        step();
        start = 1'b0;
        cnt   = 0;
        check("done_cleared", 32'(done), 32'd0);
        check("busy_after_start", 32'(busy), 32'd1);
        while (done !== 1'b1 && cnt < 1000) begin
            if (cnt < 4 * N) begin
                m  = cnt / 4;
                ph = cnt % 4;
                case (ph)
                    0:       ea = 8'(SRC + 2 * m);
                    1:       ea = 8'(SRC + 2 * m + 1);
                    2:       ea = 8'(DST + 2 * m + 1);
                    default: ea = 8'(DST + 2 * m);
                endcase
                check("sched_addr", 32'(mem_addr), 32'(ea));
            end
            if (cnt == busy_start_at) start = 1'b1;
            step();
            start = 1'b0;
            cnt++;
        end
        check("latency", cnt, 32'(exp_lat));
        check("busy_in_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int cnt, wc;
        reset   = 1'b1;
        start   = 1'b0;
        mem_gnt = 1'b1;
        for (int a = 0; a < 256; a++) mem[a] <= 8'h00;
        repeat (3) step();
        check_idle_outputs();
        reset = 1'b0;
        step();
        check_idle_outputs();

        // All-zero messages.
        run(61, -1);
        check("zero_first", 32'(mem[DST]), 32'd0);
        check("zero_last", 32'(mem[DST + 2 * N - 1]), 32'd0);
        check("write_count", wr_count, 32'(2 * N));
        check_codes(N);

        // Directed corner messages plus random ones; restarts from DONE.
        load_random_src();
        step();
        mem[0] <= 8'h01; mem[1] <= 8'h00;
        mem[2] <= 8'hFF; mem[3] <= 8'h07;
        mem[4] <= 8'h00; mem[5] <= 8'h04;
        mem[6] <= 8'h00; mem[7] <= 8'hF8;
        step();
        check("done_before_restart", 32'(done), 32'd1);
        run(61, -1);
        check("d001_lo", 32'(mem[30]), 32'h0F);
        check("d001_hi", 32'(mem[31]), 32'h00);
        check("d7ff_lo", 32'(mem[32]), 32'hFF);
        check("d7ff_hi", 32'(mem[33]), 32'hFF);
        check("d400_lo", 32'(mem[34]), 32'h17);
        check("d400_hi", 32'(mem[35]), 32'h81);
        check("mask_lo", 32'(mem[36]), 32'h00);
        check("mask_hi", 32'(mem[37]), 32'h00);
        check_codes(N);

        // start while busy must not restart the walk.
        load_random_src();
        step();
        run(61, 20);
        check_codes(N);

        // Grant withheld for 3 cycles in RD_HI of message 2.
        load_random_src();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        cnt   = 0;
        while (!(mem_req && mem_addr == 8'(SRC + 5)) && cnt < 100) begin
            step();
            cnt++;
        end
        check("reach_rdhi2", cnt, 32'd9);
        mem_gnt = 1'b0;
        wc      = wr_count;
        repeat (3) begin
            step();
            cnt++;
            check("stall_addr", 32'(mem_addr), 32'(SRC + 5));
            check("stall_wr_en", 32'(mem_wr_en), 32'd0);
        end
        check("stall_no_write", wr_count, wc);
        mem_gnt = 1'b1;
        while (done !== 1'b1 && cnt < 1000) begin
            step();
            cnt++;
        end
        check("stall_latency", cnt, 32'd64);
        check_codes(N);

        // Reset during WR_HI of message 5 with the write still ungranted.
        load_random_src();
        for (int a = 0; a < 2 * N; a++) mem[DST + a] <= 8'hA5;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        cnt   = 0;
        while (!(mem_wr_en && mem_addr == 8'(DST + 11)) && cnt < 100) begin
            step();
            cnt++;
        end
        check("reach_wrhi5", cnt, 32'd22);
        mem_gnt = 1'b0;
        reset   = 1'b1;
        step();
        reset   = 1'b0;
        mem_gnt = 1'b1;
        check_idle_outputs();
        repeat (2) step();
        check("idle_holds_req", 32'(mem_req), 32'd0);
        for (int a = 10; a < 2 * N; a++) check("untouched_dst", 32'(mem[DST + a]), 32'hA5);
        check_codes(5);
        run(61, -1);
        check_codes(N);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog1_hamming_seq.md
Name: prog1_hamming_seq

Overview:
Hardware sequencer that runs program 1 (Hamming(16,11) SECDED encode) directly against data memory. After a start pulse it walks NUM_MSG messages, reads each 11-bit message as two bytes from SRC_BASE, and computes parity p8/p4/p2/p1/p0. It writes the 16-bit codeword as two bytes at DST_BASE. It shares the data-memory port with the core through an external req/gnt arbiter, and signals completion on a level done.

Parameters:
NUM_MSG, 15, number of messages processed per run (1..127)
SRC_BASE, 0, byte address of message 0 low byte
DST_BASE, 30, byte address of codeword 0 low byte
AW, 8, data-memory address width

Ports:
clk  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle run request; sampled only in IDLE
mem_gnt  input  1  arbiter grant; a memory state advances only on a cycle with mem_gnt=1
mem_rdat  input  8  data-memory read data, combinational from mem_addr (async-read core)
mem_req  output  1  memory access request; high in every RD/WR state
mem_addr  output  AW  byte address
mem_wr_en  output  1  write strobe; effective only when mem_gnt=1
mem_wdat  output  8  write data
busy  output  1  high from first RD_LO through last WR_LO
done  output  1  registered level; high in DONE until next accepted start or reset

Behaviour:
- Reset (sync, active-high): state=IDLE, msg index i=0, data regs cleared. All outputs 0: mem_req, mem_addr, mem_wr_en, mem_wdat, busy, done. Reset mid-run aborts immediately; writes not yet granted are never issued.
- States: IDLE, RD_LO, RD_HI, WR_HI, WR_LO, DONE. Memory outputs are decoded from the registered state and i.
- IDLE: on start=1 -> RD_LO, i=0. DONE: on start=1 -> RD_LO, i=0, done cleared on the same edge. Otherwise hold.
- start while busy is ignored.
- RD_LO: addr=SRC_BASE+2i. On gnt, latch d[8:1]=mem_rdat -> RD_HI.
- RD_HI: addr=SRC_BASE+2i+1. On gnt, latch d[11:9]=mem_rdat[2:0]; bits [7:3] ignored -> WR_HI.
- WR_HI: addr=DST_BASE+2i+1, wr_en=1, wdat={d11..d5,p8}. On gnt -> WR_LO.
- WR_LO: addr=DST_BASE+2i, wr_en=1, wdat={d4,d3,d2,p4,d1,p2,p1,p0}. On gnt: if i==NUM_MSG-1 -> DONE, else i++ -> RD_LO.
- Parity:
  - p8=^d[11:5]
  - p4=^d[11:8]^^d[4:2]
  - p2=d11^d10^d7^d6^d4^d3^d1
  - p1=d11^d9^d7^d5^d4^d2^d1
  - p0=^d^p8^p4^p2^p1
- Stall: when gnt=0, state, addr, wdat and wr_en hold unchanged. There is no timeout.
- Latency with gnt tied high: start sampled at edge k; done=1 after edge k+4*NUM_MSG+1 (61 cycles for 15). Each grant-low cycle adds one cycle.
- Address arithmetic is modulo 2^AW; wrap is not flagged.

Decomposition:
- Package prog1_pkg:
  - state enum
  - codeword bit-position constants (P8_POS=8, P4_POS=4, P2_POS=2, P1_POS=1, P0_POS=0)
  - function ham_pack(d11)->16b
- Sub-module hamming_enc: combinational, 11-bit in -> 16-bit codeword. Shared with future program 2/3 checkers; the sequencer instantiates it once.

Test Plan:
- All-zero messages, gnt=1 -> every codeword 16'h0000; done high exactly 61 cycles after the start edge.
- d=11'h001 (lo 0x01, hi 0x00) -> mem[31:30]=0x00,0x0F. d=11'h7FF (lo 0xFF, hi 0x07) -> 0xFF,0xFF. d=11'h400 (hi 0x04) -> 0x81,0x17.
- Hi byte 0xF8, lo 0x00 -> codeword 0x0000, confirming bits [7:3] are masked. Then 15 random messages checked against the reference model: 15/15 match.
- gnt low 3 cycles in RD_HI of message 2 -> mem_addr holds 0x05, no write occurs, done delayed to cycle 64.
- reset asserted during WR_HI of message 5 -> next cycle all outputs 0, state IDLE, DST bytes 40..59 untouched. A new start completes normally.
- start pulsed during busy -> ignored (i unchanged). start pulsed in DONE -> done drops and the run restarts from message 0.
